// File: rtl/fir_seq_ctrl.sv
// Time-multiplexed FIR controller: a single shared MAC walks the sample ring against a writable coefficient RAM.
// Optional macro FIR_SYMMETRIC_EN folds mirrored taps to halve the MAC phase.
module fir_seq_ctrl #(
  parameter int NTAPS = 43,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [31:0]   coef_wdata,
  output logic          coef_err,
  output logic          busy
);

`ifdef FIR_SYMMETRIC_EN
  localparam int NCOEF = (NTAPS + 1) / 2;
  localparam bit ODD   = (NTAPS % 2) == 1;
`else
  localparam int NCOEF = NTAPS;
`endif
  localparam logic [AW-1:0] TAP_LAST = AW'(NCOEF - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(NTAPS - 1);
  localparam logic [AW:0]   NCOEF_V  = (AW + 1)'(NCOEF);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_next;

  logic [31:0]   hist [2**AW];
  logic [31:0]   coef [2**AW];
  logic [AW-1:0] wptr, rd_lo, tap;
  logic [63:0]   acc, prod;
  logic          accept, addr_ok, coef_ok, coef_bad;

  function automatic logic [AW-1:0] ring_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [AW-1:0] ring_dec(input logic [AW-1:0] p);
    return (p == '0) ? PTR_LAST : p - AW'(1);
  endfunction

  assign accept   = (state == IDLE) && in_valid;
  assign addr_ok  = {1'b0, coef_addr} < NCOEF_V;
  assign coef_ok  = coef_we && !rst && (state != MAC) && addr_ok;
  assign coef_bad = coef_we && ((state == MAC) || !addr_ok);

`ifdef FIR_SYMMETRIC_EN
  // rd_hi walks upward from the oldest sample while rd_lo walks down from the newest
  logic [AW-1:0] rd_hi;
  logic [32:0]   pre;
  always_comb begin
    pre = {hist[rd_lo][31], hist[rd_lo]};
    if (!(ODD && tap == TAP_LAST))
      pre = pre + {hist[rd_hi][31], hist[rd_hi]};
    prod = {{31{pre[32]}}, pre} * {{32{coef[tap][31]}}, coef[tap]};
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_hi <= '0;
    else if (accept)
      rd_hi <= ring_inc(wptr);
    else if (state == MAC)
      rd_hi <= ring_inc(rd_hi);
  end
`else
  assign prod = {{32{hist[rd_lo][31]}}, hist[rd_lo]} * {{32{coef[tap][31]}}, coef[tap]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rd_lo    <= '0;
      tap      <= '0;
      acc      <= '0;
      coef_err <= 1'b0;
      for (int i = 0; i < 2**AW; i++) hist[i] <= '0;
    end else begin
      coef_err <= coef_bad;
      if (accept) begin
        hist[wptr] <= in_data;
        wptr       <= ring_inc(wptr);
        rd_lo      <= wptr;
        tap        <= '0;
        acc        <= '0;
      end else if (state == MAC) begin
        acc   <= acc + prod;
        tap   <= tap + AW'(1);
        rd_lo <= ring_dec(rd_lo);
      end
    end
  end

  // Coefficients survive reset so a recovered pipeline keeps its filter
  always_ff @(posedge clk) begin
    if (coef_ok) coef[coef_addr] <= coef_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = MAC;
      MAC:     if (tap == TAP_LAST) state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
    busy      = (state != IDLE);
    out_data  = (state == OUT) ? acc[63:32] : '0;
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl: directed filter scenarios plus randomized traffic against a convolution model.
module tb_fir_seq_ctrl;
  localparam int NTAPS = 43;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready;
  logic          coef_we, coef_err, busy;
  logic [31:0]   in_data, out_data, coef_wdata;
  logic [AW-1:0] coef_addr;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fir_seq_ctrl #(.NTAPS(NTAPS), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(coef_err), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // Reference model: newest-first history, full convolution computed at accept time
  int          m_hist [NTAPS];
  int          m_coef [NTAPS];
  int          mac_left = 0;
  bit          m_out = 0;
  bit          m_err = 0;
  bit          model_on = 0;
  logic [31:0] m_result = '0;
  logic [31:0] got_q [$];

  always @(posedge clk) begin
    bit     idle, in_mac;
    longint sum;
    idle   = (mac_left == 0) && !m_out;
    in_mac = (mac_left > 0);
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (rst) begin
      model_on = 1;
      mac_left = 0;
      m_out    = 0;
      m_err    = 0;
      for (int k = 0; k < NTAPS; k++) m_hist[k] = 0;
    end else begin
      m_err = coef_we && (in_mac || coef_addr >= NTAPS);
      if (coef_we && !m_err) m_coef[coef_addr] = coef_wdata;
      if (idle && in_valid) begin
        for (int k = NTAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = in_data;
        sum = 0;
        for (int k = 0; k < NTAPS; k++) sum += longint'(m_coef[k]) * longint'(m_hist[k]);
        m_result = sum[63:32];
        mac_left = NTAPS;
      end else if (in_mac) begin
        mac_left--;
        if (mac_left == 0) m_out = 1;
      end else if (m_out && out_ready) begin
        m_out = 0;
      end
    end
    #1;
    if (model_on) begin
      idle = (mac_left == 0) && !m_out;
      checkOutput("in_ready", in_ready, idle);
      checkOutput("out_valid", out_valid, m_out);
      checkOutput("busy", busy, !idle);
      checkOutput("coef_err", coef_err, m_err);
      if (m_out) checkOutput("out_data", out_data, m_result);
    end
  end

  task automatic applyStimulus(input logic r, input logic iv, input logic [31:0] id, input logic ordy,
                               input logic we, input logic [AW-1:0] a, input logic [31:0] wd);
    rst = r; in_valid = iv; in_data = id; out_ready = ordy;
    coef_we = we; coef_addr = a; coef_wdata = wd;
    @(negedge clk);
  endtask

  task automatic send_sample(input logic [31:0] d, input logic ordy);
    int n = 0;
    while (!in_ready && n < 200) begin
      applyStimulus(0, 0, '0, ordy, 0, '0, '0);
      n++;
    end
    if (!in_ready) checkOutput("ready_timeout", in_ready, 1);
    applyStimulus(0, 1, d, ordy, 0, '0, '0);
  endtask

  task automatic drain();
    int n = 0;
    while (!(in_ready && !out_valid) && n < 500) begin
      applyStimulus(0, 0, '0, 1, 0, '0, '0);
      n++;
    end
    if (!in_ready) checkOutput("drain_timeout", in_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] held, e;
    rst = 1; in_valid = 0; in_data = '0; out_ready = 1;
    coef_we = 0; coef_addr = '0; coef_wdata = '0;
    @(negedge clk);
    applyStimulus(1, 0, '0, 1, 0, '0, '0);
    applyStimulus(1, 0, '0, 1, 0, '0, '0);
    applyStimulus(0, 0, '0, 1, 0, '0, '0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_busy", busy, 0);

    for (int i = 0; i < NTAPS; i++) applyStimulus(0, 0, '0, 1, 1, AW'(i), 32'h4000_0000);

    // Impulse
    got_q.delete();
    send_sample(32'h0000_1000, 1);
    lat = 1;
    while (!out_valid && lat < 100) begin
      applyStimulus(0, 0, '0, 1, 0, '0, '0);
      lat++;
    end
    checkOutput("impulse_latency", lat, 44);
    for (int i = 0; i < 44; i++) send_sample('0, 1);
    drain();
    checkOutput("impulse_count", got_q.size(), 45);
    for (int i = 0; i < 45 && i < got_q.size(); i++)
      checkOutput($sformatf("impulse_out%0d", i), got_q[i], (i < 43) ? 32'h400 : 32'h0);

    // Positive step
    got_q.delete();
    for (int i = 0; i < 50; i++) send_sample(32'h0000_0100, 1);
    drain();
    checkOutput("step_count", got_q.size(), 50);
    for (int i = 0; i < 50 && i < got_q.size(); i++) begin
      e = (i < 43) ? 32'((i + 1) * 64) : 32'h0000_0AC0;
      checkOutput($sformatf("step_out%0d", i), got_q[i], e);
    end

    // Negative step from clean history
    applyStimulus(1, 0, '0, 1, 0, '0, '0);
    got_q.delete();
    for (int i = 0; i < 50; i++) send_sample(32'hFFFF_FF00, 1);
    drain();
    checkOutput("negstep_count", got_q.size(), 50);
    for (int i = 0; i < 50 && i < got_q.size(); i++) begin
      e = (i < 43) ? 32'(-(i + 1) * 64) : 32'hFFFF_F540;
      checkOutput($sformatf("negstep_out%0d", i), got_q[i], e);
    end

    // Backpressure
    got_q.delete();
    send_sample(32'h0001_2345, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      applyStimulus(0, 0, '0, 0, 0, '0, '0);
      lat++;
    end
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, $urandom, 0, 0, '0, '0);
      checkOutput("bp_stable", out_data, held);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    applyStimulus(0, 0, '0, 1, 0, '0, '0);
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_release_ready", in_ready, 1);
    checkOutput("bp_handshakes", got_q.size(), 1);

    // Coefficient rules
    applyStimulus(1, 0, '0, 1, 0, '0, '0);
    got_q.delete();
    send_sample(32'h0000_1000, 1);
    applyStimulus(0, 0, '0, 1, 1, '0, 32'h7FFF_FFFF);
    checkOutput("mac_write_err", coef_err, 1);
    drain();
    checkOutput("mac_write_result", (got_q.size() > 0) ? got_q[0] : 32'hDEAD_BEEF, 32'h400);
    applyStimulus(0, 0, '0, 1, 1, AW'(43), 32'h1234_5678);
    checkOutput("addr43_err", coef_err, 1);
    applyStimulus(0, 0, '0, 1, 1, AW'(1), 32'h8000_0000);
    checkOutput("idle_write_noerr", coef_err, 0);
    got_q.delete();
    send_sample('0, 1);
    drain();
    checkOutput("idle_write_used", (got_q.size() > 0) ? got_q[0] : 32'hDEAD_BEEF, 32'hFFFF_F800);
    applyStimulus(0, 0, '0, 1, 1, AW'(1), 32'h4000_0000);

    // Reset mid-MAC
    got_q.delete();
    send_sample(32'h0000_5555, 1);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, '0, 1, 0, '0, '0);
    applyStimulus(1, 0, '0, 1, 0, '0, '0);
    checkOutput("midmac_out_valid", out_valid, 0);
    checkOutput("midmac_in_ready", in_ready, 1);
    send_sample(32'h0000_1000, 1);
    drain();
    checkOutput("midmac_count", got_q.size(), 1);
    checkOutput("midmac_clean", (got_q.size() > 0) ? got_q[0] : 32'hDEAD_BEEF, 32'h400);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, $urandom,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                    AW'($urandom_range(0, 47)), $urandom);
    drain();
    applyStimulus(0, 0, '0, 1, 0, '0, '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
